// File: rtl/random_pkg.sv
// random_pkg -- shared definitions for the LFSR random generator.
//   lfsr_state_e : handshake FSM state (IDLE = nothing offered, RUN = value offered)
//   TAPS_8/16/32 : maximal-length feedback masks for common widths
package random_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lfsr_state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step -- one combinational Fibonacci LFSR shift.
//   i_s : current state
//   o_s : state shifted left by one, XOR of tapped bits fed into bit 0
module lfsr_step #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] i_s,
  output logic [WIDTH-1:0] o_s
);

  assign o_s = {i_s[WIDTH-2:0], ^(i_s & TAPS)};

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen -- LFSR random generator with valid/ready output handshake.
//   clk, rst        : clock, synchronous active-high reset
//   en              : run request (IDLE->RUN, stay in RUN)
//   seed_load/_in   : load a new seed (zero seed replaced by SEED)
//   out_ready       : consumer accepts rnd_out
//   out_valid       : rnd_out holds an unconsumed value
//   rnd_out         : current LFSR state
//   seed_zero       : one-cycle pulse after a zero seed was rejected
//   wrap/period_out : period monitor outputs
// Optional build macro LFSR_PERIOD_CNT_EN adds the period monitor; without it
// wrap and period_out are constant zero.
module lfsr_gen
  import random_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] rnd_out,
  output logic             seed_zero,
  output logic             wrap,
  output logic [WIDTH-1:0] period_out
);

  lfsr_state_e            r_fsm;
  logic                   r_valid;
  logic [WIDTH-1:0]       r_state;
  logic                   r_seed_zero;

  logic [STEPS:0][WIDTH-1:0] w_chain;
  logic [WIDTH-1:0]       w_next;
  logic [WIDTH-1:0]       w_seed_eff;
  logic                   w_hs;

  // STEPS single shifts chained so one advance covers STEPS bits.
  assign w_chain[0] = r_state;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .i_s(w_chain[g]),
      .o_s(w_chain[g+1])
    );
  end
  assign w_next = w_chain[STEPS];

  assign w_seed_eff = (seed_in == '0) ? SEED : seed_in;
  assign w_hs       = r_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_valid     <= 1'b0;
      r_state     <= SEED;
      r_seed_zero <= 1'b0;
    end else begin
      r_seed_zero <= 1'b0;
      if (seed_load) begin
        // Load wins over an advance; a coincident handshake is simply consumed.
        r_state     <= w_seed_eff;
        r_seed_zero <= (seed_in == '0);
      end else begin
        case (r_fsm)
          ST_IDLE: if (en) begin
            r_fsm   <= ST_RUN;
            r_valid <= 1'b1;
          end
          ST_RUN: if (w_hs) begin
            r_state <= w_next;
            if (!en) begin
              r_fsm   <= ST_IDLE;
              r_valid <= 1'b0;
            end
          end
          default: begin
            r_fsm   <= ST_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid = r_valid;
  assign rnd_out   = r_state;
  assign seed_zero = r_seed_zero;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_period;
  logic             r_wrap;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_adv;

  assign w_adv     = w_hs & ~seed_load;
  // Saturate so an aperiodic TAPS choice cannot roll the count over.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_ref    <= SEED;
      r_period <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (seed_load) begin
        r_cnt <= '0;
        r_ref <= w_seed_eff;
      end else if (w_adv) begin
        if (w_next == r_ref) begin
          r_wrap   <= 1'b1;
          r_period <= w_cnt_inc;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign wrap       = r_wrap;
  assign period_out = r_period;
`else
  assign wrap       = 1'b0;
  assign period_out = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen -- self-checking bench: two instances (8-bit STEPS=1 defaults,
// 16-bit STEPS=16) driven with shared controls, checked each cycle against a
// behavioural model, plus hand-computed literal expectations.
module tb_lfsr_gen;
  import random_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sl = 1'b0;
  logic        rdy = 1'b0;
  logic [7:0]  si_a = '0;
  logic [15:0] si_b = '0;

  logic        vld_a, sz_a, wr_a;
  logic [7:0]  rnd_a, per_a;
  logic        vld_b, sz_b, wr_b;
  logic [15:0] rnd_b, per_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lfsr_gen u_a (
    .clk(clk), .rst(rst), .en(en), .seed_load(sl), .seed_in(si_a),
    .out_ready(rdy), .out_valid(vld_a), .rnd_out(rnd_a),
    .seed_zero(sz_a), .wrap(wr_a), .period_out(per_a)
  );

  lfsr_gen #(.WIDTH(16), .TAPS(TAPS_16), .SEED(16'h0001), .STEPS(16)) u_b (
    .clk(clk), .rst(rst), .en(en), .seed_load(sl), .seed_in(si_b),
    .out_ready(rdy), .out_valid(vld_b), .rnd_out(rnd_b),
    .seed_zero(sz_b), .wrap(wr_b), .period_out(per_b)
  );

  typedef struct {
    logic [31:0] st;
    logic [31:0] ref_s;
    logic [31:0] per;
    int          cnt;
    bit          vld;
    bit          sz;
    bit          wr;
  } mdl_t;

  mdl_t ma, mb;

  // Apply the single-bit shift rule `steps` times.
  function automatic logic [31:0] adv(input logic [31:0] s, input logic [31:0] taps,
                                      input int w, input int steps);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < steps; i++) s = ((s << 1) | {31'b0, ^(s & taps)}) & mask;
    return s;
  endfunction

  function automatic mdl_t mupd(input mdl_t m, input bit r, input bit e, input bit load,
                                input bit ready, input logic [31:0] si, input int w,
                                input logic [31:0] taps, input int steps,
                                input logic [31:0] seed);
    mdl_t        n;
    logic [31:0] nx;
    int          maxc;
    n    = m;
    n.sz = 1'b0;
    n.wr = 1'b0;
    maxc = (1 << w) - 1;
    if (r) begin
      n.st = seed; n.ref_s = seed; n.vld = 1'b0; n.per = 0; n.cnt = 0;
    end else if (load) begin
      n.st    = (si == 0) ? seed : si;
      n.ref_s = n.st;
      n.cnt   = 0;
      n.sz    = (si == 0);
    end else if (m.vld && ready) begin
      nx   = adv(m.st, taps, w, steps);
      n.st = nx;
      if (nx == m.ref_s) begin
        n.wr  = 1'b1;
        n.per = (m.cnt + 1 > maxc) ? maxc : m.cnt + 1;
        n.cnt = 0;
      end else begin
        n.cnt = m.cnt + 1;
      end
      if (!e) n.vld = 1'b0;
    end else if (!m.vld && e) begin
      n.vld = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mupd(ma, rst, en, sl, rdy, {24'b0, si_a}, 8, 32'hB8, 1, 32'h01);
    mb <= mupd(mb, rst, en, sl, rdy, {16'b0, si_b}, 16, {16'b0, TAPS_16}, 16, 32'h0001);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_rnd", {24'b0, rnd_a}, ma.st);
      chk("a_vld", {31'b0, vld_a}, {31'b0, ma.vld});
      chk("a_sz",  {31'b0, sz_a},  {31'b0, ma.sz});
      chk("a_nonzero", {31'b0, rnd_a == 8'h00}, 32'd0);
      chk("b_rnd", {16'b0, rnd_b}, mb.st);
      chk("b_vld", {31'b0, vld_b}, {31'b0, mb.vld});
      chk("b_sz",  {31'b0, sz_b},  {31'b0, mb.sz});
`ifdef LFSR_PERIOD_CNT_EN
      chk("a_wrap", {31'b0, wr_a}, {31'b0, ma.wr});
      chk("a_per",  {24'b0, per_a}, ma.per);
      chk("b_wrap", {31'b0, wr_b}, {31'b0, mb.wr});
      chk("b_per",  {16'b0, per_b}, mb.per);
`else
      chk("a_wrap", {31'b0, wr_a}, 32'd0);
      chk("a_per",  {24'b0, per_a}, 32'd0);
      chk("b_wrap", {31'b0, wr_b}, 32'd0);
      chk("b_per",  {16'b0, per_b}, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq [5];
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h11;

    // Reset
    repeat (3) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rnd", {24'b0, rnd_a}, 32'h01);
    chk("rst_vld", {31'b0, vld_a}, 32'd0);
    chk("rst_rnd_b", {16'b0, rnd_b}, 32'h0001);

    // First outputs after enabling with the consumer always ready
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("seq", {24'b0, rnd_a}, {24'b0, seq[i]});
      chk("seq_vld", {31'b0, vld_a}, 32'd1);
    end

    // Run past a full 255-advance period
    repeat (260) tick();
`ifdef LFSR_PERIOD_CNT_EN
    @(negedge clk);
    chk("period255", {24'b0, per_a}, 32'd255);
`endif

    // Zero seed rejected while a handshake coincides
    tick();
    sl = 1'b1; si_a = 8'h00; si_b = 16'h0000;
    tick();
    sl = 1'b0;
    @(negedge clk);
    chk("zseed_rnd", {24'b0, rnd_a}, 32'h01);
    chk("zseed_pulse", {31'b0, sz_a}, 32'd1);
    tick();
    @(negedge clk);
    chk("zseed_pulse_end", {31'b0, sz_a}, 32'd0);
    chk("zseed_adv", {24'b0, rnd_a}, 32'h02);

    // Load beats a coincident handshake
    sl = 1'b1; si_a = 8'h5A; si_b = 16'hBEEF;
    tick();
    sl = 1'b0; rdy = 1'b0;
    @(negedge clk);
    chk("load_5a", {24'b0, rnd_a}, 32'h5A);

    // Backpressure: value and valid held, no drop without a handshake
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("hold_rnd", {24'b0, rnd_a}, 32'h5A);
      chk("hold_vld", {31'b0, vld_a}, 32'd1);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("hold_en0_vld", {31'b0, vld_a}, 32'd1);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    @(negedge clk);
    chk("idle_vld", {31'b0, vld_a}, 32'd0);
    chk("idle_rnd", {24'b0, rnd_a}, 32'hB4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 1) == 1);
      sl   = ($urandom_range(0, 15) == 0);
      si_a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      si_b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    end

    // Reset in the middle of a run
    tick();
    rst = 1'b0; sl = 1'b0; en = 1'b1; rdy = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("midrst_rnd_b", {16'b0, rnd_b}, 32'h0001);
    chk("midrst_vld_b", {31'b0, vld_b}, 32'd0);
    chk("midrst_rnd_a", {24'b0, rnd_a}, 32'h01);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
